// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and the {valid, instr, pc} entry type for the fetch unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] TEXT_BASE        = 32'h0000_3000;
  localparam logic [31:0] TEXT_END         = 32'h0000_6FFC;

  typedef enum logic [1:0] {
    REQ  = 2'b00,
    WAIT = 2'b01,
    HOLD = 2'b10,
    DROP = 2'b11
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // A fetch from addr faults when it is misaligned or outside the text segment.
  function automatic logic fetch_addr_bad(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || (addr < TEXT_BASE) || (addr > TEXT_END);
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched instruction that ID could not take yet.
module fetch_skid
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  fetch_entry_t load_entry,
  input  logic         unload,
  input  logic         clear,
  output fetch_entry_t entry
);

  // Holding register: clear and unload both empty it, load captures a new entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry <= '0;
    end else if (clear || unload) begin
      entry.valid <= 1'b0;
    end else if (load) begin
      entry <= load_entry;
    end else begin
      entry <= entry;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch: PC, single-outstanding imem reads, output register and skid.
// Optional fetch address checking is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_adel
);

  fetch_state_e state_r, state_s;
  logic [31:0]  pc_r, pc_s, req_pc_r, req_pc_s;
  fetch_entry_t out_r, out_data_s, skid_s, skid_in_s;
  logic         out_load_s, skid_load_s, skid_unload_s, skid_clear_s;
  logic         consume_s, out_free_s, addr_bad_s;

  assign consume_s     = out_r.valid & ~stall;
  assign out_free_s    = ~out_r.valid | ~stall;
  assign skid_in_s     = '{valid: 1'b1, instr: imem_rsp_data, pc: req_pc_r};
  assign imem_req_addr = pc_r;
  assign if_valid      = out_r.valid;
  assign if_instr      = out_r.instr;
  assign if_pc         = out_r.pc;

`ifdef FETCH_ALIGN_CHECK_EN
  assign addr_bad_s = fetch_addr_bad(pc_r);
`else
  assign addr_bad_s = 1'b0;
`endif

  // Next-state, request handshake and load decisions; redirect outranks everything.
  always_comb begin
    state_s        = state_r;
    req_pc_s       = req_pc_r;
    imem_req_valid = 1'b0;
    out_load_s     = 1'b0;
    out_data_s     = skid_in_s;
    skid_load_s    = 1'b0;
    skid_unload_s  = 1'b0;
    skid_clear_s   = 1'b0;
    if (redirect_valid) begin
      pc_s = redirect_pc;
    end else begin
      pc_s = pc_r;
    end
    case (state_r)
      REQ: begin
        if (redirect_valid || reset) begin
          state_s = REQ;
        end else if (addr_bad_s) begin
          // Faulting PC: present an error entry instead of fetching; PC waits for a redirect.
          out_load_s = out_free_s;
          out_data_s = '{valid: 1'b1, instr: 32'h0000_0000, pc: pc_r};
        end else begin
          imem_req_valid = out_free_s;
          if (out_free_s && imem_req_ready) begin
            req_pc_s = pc_r;
            pc_s     = pc_r + 32'd4;
            state_s  = WAIT;
          end else begin
            state_s = REQ;
          end
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            state_s = REQ;
          end else if (out_free_s) begin
            out_load_s = 1'b1;
            state_s    = REQ;
          end else begin
            skid_load_s = 1'b1;
            state_s     = HOLD;
          end
        end else if (redirect_valid) begin
          state_s = DROP;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_clear_s = 1'b1;
          state_s      = REQ;
        end else if (consume_s) begin
          skid_unload_s = 1'b1;
          out_load_s    = 1'b1;
          out_data_s    = skid_s;
          state_s       = REQ;
        end else begin
          state_s = HOLD;
        end
      end
      DROP: begin
        // The stale response is swallowed even if another redirect lands alongside it.
        if (imem_rsp_valid) begin
          state_s = REQ;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = REQ;
      end
    endcase
  end

  // State, architectural PC and in-flight request address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      req_pc_r <= req_pc_s;
    end
  end

  // Output register presented to ID; empties on consume unless refilled.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_r <= '0;
    end else if (out_load_s) begin
      out_r <= out_data_s;
    end else if (consume_s) begin
      out_r.valid <= 1'b0;
    end else begin
      out_r <= out_r;
    end
  end

  fetch_skid u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load_s),
    .load_entry (skid_in_s),
    .unload     (skid_unload_s),
    .clear      (skid_clear_s),
    .entry      (skid_s)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  logic adel_r;
  // Fault flag rides with the output entry; only a load in REQ is an error entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      adel_r <= 1'b0;
    end else if (out_load_s) begin
      adel_r <= (state_r == REQ);
    end else if (consume_s) begin
      adel_r <= 1'b0;
    end else begin
      adel_r <= adel_r;
    end
  end
  assign if_adel = adel_r;
`else
  assign if_adel = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, corner sequences, random run vs queue model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, stall, imem_req_ready, imem_rsp_valid;
  logic [31:0] redirect_pc, imem_rsp_data;
  logic        imem_req_valid, if_valid, if_adel;
  logic [31:0] imem_req_addr, if_instr, if_pc;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_adel        (if_adel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what ID should see is a FIFO of fetched entries (front = output register).
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } mentry_t;
  mentry_t     m_q[$];
  logic [31:0] m_pc     = 32'h0000_3000;
  logic [31:0] m_req_pc = 32'h0000_0000;
  logic        m_inflight = 1'b0;
  logic        m_drop     = 1'b0;

  // Behavioural instruction memory with one outstanding request.
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0000_0000;
  int          mem_cnt  = 0;

  logic        samp_req_valid;
  logic [31:0] samp_req_addr;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    int          lat;
    logic        er;
    logic [31:0] ea;
    logic        eiv;
    logic [31:0] eipc;
  } vec_t;
  vec_t tbl[26];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h0F0F};
  endfunction

  function automatic logic pc_bad(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a > 32'h0000_6FFC);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the request against the model, advance, check if_*.
  task automatic step(input logic rst, input logic st, input logic rv, input logic [31:0] rpc,
                      input logic rdy, input int lat);
    logic rsp_now, exp_req, fire, err, bad_pc;
    reset          = rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_req_ready = rdy;
    rsp_now        = mem_busy && (mem_cnt == 0);
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(mem_addr) : 32'h0000_0000;
    #1;
    samp_req_valid = imem_req_valid;
    samp_req_addr  = imem_req_addr;
    bad_pc  = pc_bad(m_pc);
    exp_req = !rst && !m_inflight && !rv && !bad_pc &&
              (m_q.size() == 0 || (m_q.size() == 1 && !st));
    check("req_valid", samp_req_valid, exp_req);
    if (exp_req) check("req_addr", samp_req_addr, m_pc);
    fire = exp_req && rdy;
    if (rst) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_drop     = 1'b0;
      m_pc       = 32'h0000_3000;
    end else begin
      if (rv && m_q.size() == 2) void'(m_q.pop_back());
      err = !m_inflight && !rv && bad_pc && m_q.size() <= 1 && (m_q.size() == 0 || !st);
      if (m_q.size() > 0 && !st) void'(m_q.pop_front());
      if (rsp_now && m_inflight) begin
        if (!m_drop && !rv) m_q.push_back('{instr_of(m_req_pc), m_req_pc, 1'b0});
        m_inflight = 1'b0;
        m_drop     = 1'b0;
      end else if (rv && m_inflight) begin
        m_drop = 1'b1;
      end
      if (err) m_q.push_back('{32'h0000_0000, m_pc, 1'b1});
      if (rv) begin
        m_pc = rpc;
      end else if (fire) begin
        m_req_pc   = m_pc;
        m_pc       = m_pc + 32'd4;
        m_inflight = 1'b1;
      end
    end
    if (rsp_now) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (samp_req_valid && rdy) begin
      mem_busy = 1'b1;
      mem_addr = samp_req_addr;
      mem_cnt  = lat - 1;
    end
    if (rst && mem_busy) mem_cnt = 0;
    @(posedge clk);
    #1;
    check("if_valid", if_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("if_pc", if_pc, m_q[0].pc);
      check("if_instr", if_instr, m_q[0].instr);
      check("if_adel", if_adel, m_q[0].adel);
    end
  endtask

  initial begin
    logic        st, rv, rdy, rst;
    logic [31:0] rpc;

    // st rv rpc rdy lat | exp_req exp_addr exp_if_valid exp_if_pc
    tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3000, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3000};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3004, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3004};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3008, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3008};
    tbl[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h300C, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h300C};
    tbl[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 2, 1'b1, 32'h3010, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b1, 32'h3100, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3100, 1'b0, 32'h0};
    tbl[17] = '{1'b0, 1'b1, 32'h3200, 1'b1, 1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[18] = '{1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h3200, 1'b0, 32'h0};
    tbl[19] = '{1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h3200, 1'b0, 32'h0};
    tbl[20] = '{1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1, 32'h3200, 1'b0, 32'h0};
    tbl[21] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3200, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3200};
    tbl[23] = '{1'b1, 1'b1, 32'h3300, 1'b1, 1, 1'b0, 32'h0, 1'b1, 32'h3200};
    tbl[24] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b1, 32'h3300, 1'b0, 32'h0};
    tbl[25] = '{1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0, 32'h0,    1'b1, 32'h3300};

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("reset_if_valid", if_valid, 32'h0);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_if_instr", if_instr, 32'h0);
    check("reset_if_adel", if_adel, 32'h0);

    for (int i = 0; i < 26; i++) begin
      step(1'b0, tbl[i].st, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].lat);
      check($sformatf("tbl%0d_req_valid", i), samp_req_valid, tbl[i].er);
      if (tbl[i].er) check($sformatf("tbl%0d_req_addr", i), samp_req_addr, tbl[i].ea);
      check($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].eiv);
      if (tbl[i].eiv) begin
        check($sformatf("tbl%0d_if_pc", i), if_pc, tbl[i].eipc);
        check($sformatf("tbl%0d_if_instr", i), if_instr, instr_of(tbl[i].eipc));
      end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect: error entry, no request, then recovery via a good redirect.
    step(1'b0, 1'b0, 1'b1, 32'h3002, 1'b1, 1);
    check("adel_redirect_req", samp_req_valid, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("adel_no_req", samp_req_valid, 32'h0);
    check("adel_if_valid", if_valid, 32'h1);
    check("adel_flag", if_adel, 32'h1);
    check("adel_instr", if_instr, 32'h0);
    check("adel_pc", if_pc, 32'h3002);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1);
    check("adel_hold_flag", if_adel, 32'h1);
    step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1, 1);
    check("adel_cleared", if_adel, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("adel_resume_req", samp_req_valid, 32'h1);
    check("adel_resume_addr", samp_req_addr, 32'h3000);
`else
    // PC wraps modulo 2^32 after the last word.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_req_addr", samp_req_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
    check("wrap_next_valid", samp_req_valid, 32'h1);
    check("wrap_next_addr", samp_req_addr, 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom % 300) == 0;
      st  = ($urandom % 4) == 0;
      rv  = ($urandom % 10) == 0;
      rdy = ($urandom % 4) != 0;
      rpc = 32'h0000_3000 + {20'h0, $urandom_range(0, 1023), 2'b00};
`ifdef FETCH_ALIGN_CHECK_EN
      if (($urandom % 20) == 0) rpc = rpc | 32'h0000_0002;
`else
      if (($urandom % 50) == 0) rpc = 32'hFFFF_FFF8;
`endif
      step(rst, st, rv, rpc, rdy, $urandom_range(1, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
